// File: rtl/fu_issue_queue.sv
// Per-functional-unit reservation station: age-ordered collapsing queue that
// captures operands from the writeback bus and issues the oldest ready entry.
module fu_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int INST_ID_BITS = 8,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int WB_PORTS     = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   disp_valid,
  output logic                                   disp_ready,
  input  logic [INST_ID_BITS-1:0]                disp_inst_id,
  input  logic [31:0]                            disp_inst,
  input  logic [63:0]                            disp_pc,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  disp_src_prn,
  input  logic [MAX_OPERANDS-1:0]                disp_src_rdy,
  input  logic [MAX_OPERANDS-1:0][63:0]          disp_src_val,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  disp_dst_prn,
  input  logic [WB_PORTS-1:0]                    wb_valid,
  input  logic [WB_PORTS-1:0][PRN_BITS-1:0]      wb_prn,
  input  logic [WB_PORTS-1:0][63:0]              wb_data,
  input  logic                                   fu_ready,
  output logic                                   inst_valid,
  output logic [INST_ID_BITS-1:0]                inst_id,
  output logic [31:0]                            inst,
  output logic [MAX_OPERANDS-1:0][63:0]          op,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn,
  output logic [63:0]                            pc,
  output logic [$clog2(DEPTH+1)-1:0]             count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                id;
    logic [31:0]                            inst;
    logic [63:0]                            pc;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dst;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  src_prn;
    logic [MAX_OPERANDS-1:0]                src_rdy;
    logic [MAX_OPERANDS-1:0][63:0]          src_val;
  } entry_t;

  // Handshakes: a dispatch transfers on a rising edge where disp_valid && disp_ready;
  // disp_ready depends only on count and flush, never on disp_valid. An issue
  // transfers on a rising edge where a ready entry exists and fu_ready is high, and
  // inst_valid is then high for exactly the one following cycle.

  entry_t                      ent_q [DEPTH];
  entry_t                      ent_d [DEPTH];
  entry_t                      woken [DEPTH];
  entry_t                      new_ent;
  entry_t                      sel_ent;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            base_cnt;
  logic [CNT_W-1:0]            sel_idx;
  logic                        sel_found;
  logic                        do_accept;
  logic                        do_issue;

  logic                                   inst_valid_q, inst_valid_d;
  logic [INST_ID_BITS-1:0]                iss_id_q, iss_id_d;
  logic [31:0]                            iss_inst_q, iss_inst_d;
  logic [63:0]                            iss_pc_q, iss_pc_d;
  logic [MAX_OPERANDS-1:0][63:0]          iss_op_q, iss_op_d;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  iss_prn_q, iss_prn_d;

  // Descending port scan with last-write-wins makes the lowest matching port win.
  function automatic entry_t wake(
    input entry_t                                e,
    input logic [WB_PORTS-1:0]                   v,
    input logic [WB_PORTS-1:0][PRN_BITS-1:0]     tag,
    input logic [WB_PORTS-1:0][63:0]             data
  );
    entry_t r;
    r = e;
    for (int s = 0; s < MAX_OPERANDS; s++) begin
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (!e.src_rdy[s] && v[p] && (tag[p] == e.src_prn[s])) begin
          r.src_rdy[s] = 1'b1;
          r.src_val[s] = data[p];
        end
      end
    end
    return r;
  endfunction

  assign disp_ready = (count_q < CNT_W'(DEPTH)) && !flush;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_ent   = ent_q[0];
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && (&ent_q[i].src_rdy)) begin
        sel_found = 1'b1;
        sel_idx   = CNT_W'(i);
        sel_ent   = ent_q[i];
      end
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.id      = disp_inst_id;
    new_ent.inst    = disp_inst;
    new_ent.pc      = disp_pc;
    new_ent.dst     = disp_dst_prn;
    new_ent.src_prn = disp_src_prn;
    new_ent.src_rdy = disp_src_rdy;
    new_ent.src_val = disp_src_val;
    new_ent         = wake(new_ent, wb_valid, wb_prn, wb_data);
  end

  always_comb begin
    do_accept = disp_valid && disp_ready;
    do_issue  = sel_found && fu_ready && !flush;

    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake(ent_q[i], wb_valid, wb_prn, wb_data);
    end

    // Collapse above the issued slot, then append behind the surviving entries.
    base_cnt = count_q - CNT_W'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = woken[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_issue && (CNT_W'(i) >= sel_idx)) begin
        ent_d[i] = woken[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_accept && (CNT_W'(i) == base_cnt)) begin
        ent_d[i] = new_ent;
      end
    end
    count_d = base_cnt + CNT_W'(do_accept);

    inst_valid_d = do_issue;
    iss_id_d     = iss_id_q;
    iss_inst_d   = iss_inst_q;
    iss_pc_d     = iss_pc_q;
    iss_op_d     = iss_op_q;
    iss_prn_d    = iss_prn_q;
    if (do_issue) begin
      iss_id_d   = sel_ent.id;
      iss_inst_d = sel_ent.inst;
      iss_pc_d   = sel_ent.pc;
      iss_op_d   = sel_ent.src_val;
      iss_prn_d  = sel_ent.dst;
    end

    if (flush) begin
      count_d      = '0;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q      <= '0;
      inst_valid_q <= 1'b0;
      iss_id_q     <= '0;
      iss_inst_q   <= '0;
      iss_pc_q     <= '0;
      iss_op_q     <= '0;
      iss_prn_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q      <= count_d;
      inst_valid_q <= inst_valid_d;
      iss_id_q     <= iss_id_d;
      iss_inst_q   <= iss_inst_d;
      iss_pc_q     <= iss_pc_d;
      iss_op_q     <= iss_op_d;
      iss_prn_q    <= iss_prn_d;
    end
  end

  assign count      = count_q;
  assign inst_valid = inst_valid_q;
  assign inst_id    = iss_id_q;
  assign inst       = iss_inst_q;
  assign pc         = iss_pc_q;
  assign op         = iss_op_q;
  assign out_prn    = iss_prn_q;

endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_fu_issue_queue;

  localparam int DEPTH = 8;
  localparam int IDW   = 8;
  localparam int PRNW  = 6;
  localparam int NOPS  = 3;
  localparam int NWB   = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BUSW  = IDW + 32 + 64 + NOPS * 64 + NOPS * PRNW;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic                          disp_valid;
  logic                          disp_ready;
  logic [IDW-1:0]                disp_inst_id;
  logic [31:0]                   disp_inst;
  logic [63:0]                   disp_pc;
  logic [NOPS-1:0][PRNW-1:0]     disp_src_prn;
  logic [NOPS-1:0]               disp_src_rdy;
  logic [NOPS-1:0][63:0]         disp_src_val;
  logic [NOPS-1:0][PRNW-1:0]     disp_dst_prn;
  logic [NWB-1:0]                wb_valid;
  logic [NWB-1:0][PRNW-1:0]      wb_prn;
  logic [NWB-1:0][63:0]          wb_data;
  logic                          fu_ready;
  logic                          inst_valid;
  logic [IDW-1:0]                inst_id;
  logic [31:0]                   inst;
  logic [NOPS-1:0][63:0]         op;
  logic [NOPS-1:0][PRNW-1:0]     out_prn;
  logic [63:0]                   pc;
  logic [CW-1:0]                 count;
  logic [BUSW-1:0]               iss_bus;

  fu_issue_queue #(
    .DEPTH(DEPTH), .INST_ID_BITS(IDW), .PRN_BITS(PRNW),
    .MAX_OPERANDS(NOPS), .WB_PORTS(NWB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst_id(disp_inst_id), .disp_inst(disp_inst), .disp_pc(disp_pc),
    .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy),
    .disp_src_val(disp_src_val), .disp_dst_prn(disp_dst_prn),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .wb_data(wb_data),
    .fu_ready(fu_ready), .inst_valid(inst_valid), .inst_id(inst_id),
    .inst(inst), .op(op), .out_prn(out_prn), .pc(pc), .count(count)
  );

  assign iss_bus = {inst_id, inst, pc, op, out_prn};

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: age-ordered list of waiting instructions
  typedef struct packed {
    logic [IDW-1:0]             id;
    logic [31:0]                inst;
    logic [63:0]                pc;
    logic [NOPS-1:0][PRNW-1:0]  dst;
    logic [NOPS-1:0][PRNW-1:0]  prn;
    logic [NOPS-1:0]            rdy;
    logic [NOPS-1:0][63:0]      val;
  } m_ent_t;

  m_ent_t          mq[$];
  logic [BUSW-1:0] exp_q[$];
  logic            m_valid;
  logic [BUSW-1:0] m_last;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [BUSW-1:0] got, input logic [BUSW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t r;
    r = e;
    for (int s = 0; s < NOPS; s++) begin
      if (!e.rdy[s]) begin
        for (int p = 0; p < NWB; p++) begin
          if (!r.rdy[s] && wb_valid[p] && (wb_prn[p] == e.prn[s])) begin
            r.rdy[s] = 1'b1;
            r.val[s] = wb_data[p];
          end
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = '0;
  endtask

  task automatic model_step();
    int     sel;
    bit     acc;
    bit     iss;
    m_ent_t e;
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      return;
    end
    acc = disp_valid && (mq.size() < DEPTH);
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && (&mq[i].rdy)) sel = i;
    end
    iss = (sel >= 0) && fu_ready;
    m_valid = iss;
    if (iss) begin
      m_last = {mq[sel].id, mq[sel].inst, mq[sel].pc, mq[sel].val, mq[sel].dst};
      exp_q.push_back(m_last);
    end
    for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
    if (iss) mq.delete(sel);
    if (acc) begin
      e.id   = disp_inst_id;
      e.inst = disp_inst;
      e.pc   = disp_pc;
      e.dst  = disp_dst_prn;
      e.prn  = disp_src_prn;
      e.rdy  = disp_src_rdy;
      e.val  = disp_src_val;
      mq.push_back(m_wake(e));
    end
  endtask

  // One clock: check ready with inputs applied, advance model, compare outputs.
  task automatic step();
    #1;
    check("disp_ready", BUSW'(disp_ready), BUSW'((mq.size() < DEPTH) && !flush));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("count", BUSW'(count), BUSW'(mq.size()));
    check("inst_valid", BUSW'(inst_valid), BUSW'(m_valid));
    if (inst_valid) begin
      check("issue_pending", BUSW'(exp_q.size() > 0), BUSW'(1'b1));
      if (exp_q.size() > 0) check("issue", iss_bus, exp_q.pop_front());
    end else begin
      check("issue_hold", iss_bus, m_last);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    disp_valid = 1'b0;
    wb_valid   = '0;
    flush      = 1'b0;
  endtask

  task automatic drive_disp(input logic [IDW-1:0] id, input logic [NOPS-1:0] rdy,
                            input logic [NOPS-1:0][PRNW-1:0] prn,
                            input logic [NOPS-1:0][63:0] val,
                            input logic [NOPS-1:0][PRNW-1:0] dst);
    disp_valid   = 1'b1;
    disp_inst_id = id;
    disp_inst    = $urandom;
    disp_pc      = {$urandom, $urandom};
    disp_src_rdy = rdy;
    disp_src_prn = prn;
    disp_src_val = val;
    disp_dst_prn = dst;
  endtask

  task automatic drive_wb(input int p, input logic [PRNW-1:0] tag, input logic [63:0] data);
    wb_valid[p] = 1'b1;
    wb_prn[p]   = tag;
    wb_data[p]  = data;
  endtask

  task automatic drive_rand_disp();
    logic [NOPS-1:0][PRNW-1:0] rp;
    logic [NOPS-1:0][PRNW-1:0] rd;
    logic [NOPS-1:0][63:0]     rv;
    for (int s = 0; s < NOPS; s++) begin
      rp[s] = PRNW'($urandom_range(0, 15));
      rd[s] = PRNW'($urandom);
      rv[s] = {$urandom, $urandom};
    end
    drive_disp(IDW'($urandom), NOPS'($urandom | $urandom), rp, rv, rd);
  endtask

  task automatic wait_issue(input string tag, input logic [IDW-1:0] id, input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      step();
      n++;
    end
    check({tag, "_valid"}, BUSW'(inst_valid), BUSW'(1'b1));
    check({tag, "_id"}, BUSW'(inst_id), BUSW'(id));
  endtask

  initial begin
    rst          = 1'b1;
    fu_ready     = 1'b0;
    disp_inst_id = '0;
    disp_inst    = '0;
    disp_pc      = '0;
    disp_src_prn = '0;
    disp_src_rdy = '0;
    disp_src_val = '0;
    disp_dst_prn = '0;
    wb_prn       = '0;
    wb_data      = '0;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_count", BUSW'(count), BUSW'(0));
    check("rst_valid", BUSW'(inst_valid), BUSW'(0));
    check("rst_bus", iss_bus, BUSW'(0));
    check("rst_ready", BUSW'(disp_ready), BUSW'(1));
    @(negedge clk);

    // Two-cycle minimum latency
    fu_ready = 1'b1;
    drive_disp(8'd5, 3'b111, {6'd3, 6'd2, 6'd1}, {64'd3, 64'd2, 64'd1}, {6'd12, 6'd11, 6'd10});
    step();
    drive_idle();
    step();
    check("t1_valid", BUSW'(inst_valid), BUSW'(1));
    check("t1_id", BUSW'(inst_id), BUSW'(5));
    check("t1_op", BUSW'(op), BUSW'({64'd3, 64'd2, 64'd1}));
    check("t1_prn", BUSW'(out_prn), BUSW'({6'd12, 6'd11, 6'd10}));
    step();
    check("t1_count", BUSW'(count), BUSW'(0));

    // Wakeup on wb port 1, issue the cycle after capture
    drive_disp(8'd7, 3'b110, {6'd22, 6'd21, 6'd20}, {64'd9, 64'd8, 64'd0}, {6'd3, 6'd2, 6'd1});
    step();
    drive_idle();
    step();
    step();
    drive_wb(1, 6'd20, 64'hABCD);
    step();
    check("t2_no_bypass", BUSW'(inst_valid), BUSW'(0));
    drive_idle();
    step();
    check("t2_valid", BUSW'(inst_valid), BUSW'(1));
    check("t2_id", BUSW'(inst_id), BUSW'(7));
    check("t2_op0", BUSW'(op[0]), BUSW'(64'hABCD));

    // Out-of-order readiness, oldest-ready selection
    drive_disp(8'd1, 3'b110, {6'd50, 6'd50, 6'd30}, '0, '0);
    step();
    drive_disp(8'd2, 3'b110, {6'd50, 6'd50, 6'd31}, '0, '0);
    step();
    drive_disp(8'd3, 3'b111, {6'd50, 6'd50, 6'd50}, {64'd6, 64'd5, 64'd4}, '0);
    step();
    drive_idle();
    step();
    check("t3_first", BUSW'(inst_id), BUSW'(3));
    drive_wb(0, 6'd30, 64'h1111);
    step();
    drive_idle();
    step();
    check("t3_second", BUSW'(inst_id), BUSW'(1));
    check("t3_count", BUSW'(count), BUSW'(1));
    drive_wb(0, 6'd31, 64'h2222);
    step();
    drive_idle();
    wait_issue("t3_drain", 8'd2, 4);

    // Full queue, dropped dispatch, freeing an entry
    for (int k = 0; k < DEPTH; k++) begin
      drive_disp(IDW'(8'h40 + k), 3'b110, {6'd51, 6'd51, PRNW'(40 + k)}, '0, '0);
      step();
    end
    drive_disp(8'h48, 3'b111, '0, '0, '0);
    #1;
    check("t4_full_ready", BUSW'(disp_ready), BUSW'(0));
    step();
    check("t4_full_count", BUSW'(count), BUSW'(8));
    drive_idle();
    drive_wb(0, 6'd40, 64'h40);
    step();
    drive_idle();
    #1;
    check("t4_ready_during_issue", BUSW'(disp_ready), BUSW'(0));
    step();
    check("t4_issue", BUSW'(inst_id), BUSW'(8'h40));
    check("t4_ready_after", BUSW'(disp_ready), BUSW'(1));
    drive_wb(0, 6'd41, 64'h41);
    drive_wb(1, 6'd42, 64'h42);
    drive_wb(2, 6'd43, 64'h43);
    step();
    drive_idle();
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t4_seq", BUSW'(inst_id), BUSW'(8'h40 + k));
    end

    // Flush with a same-cycle dispatch
    check("t6_pre_count", BUSW'(count), BUSW'(4));
    drive_disp(8'h60, 3'b111, '0, '0, '0);
    flush = 1'b1;
    step();
    check("t6_count", BUSW'(count), BUSW'(0));
    check("t6_valid", BUSW'(inst_valid), BUSW'(0));
    drive_idle();

    // Back-pressure from the FU
    fu_ready = 1'b0;
    drive_disp(8'h50, 3'b111, '0, {64'd1, 64'd2, 64'd3}, '0);
    step();
    drive_disp(8'h51, 3'b111, '0, {64'd4, 64'd5, 64'd6}, '0);
    step();
    drive_idle();
    step();
    check("t5_stall", BUSW'(inst_valid), BUSW'(0));
    fu_ready = 1'b1;
    step();
    check("t5_first", BUSW'(inst_id), BUSW'(8'h50));
    step();
    check("t5_second_valid", BUSW'(inst_valid), BUSW'(1));
    check("t5_second", BUSW'(inst_id), BUSW'(8'h51));

    // Asynchronous reset mid-stream
    fu_ready = 1'b0;
    drive_disp(8'h70, 3'b111, '0, '0, '0);
    step();
    drive_disp(8'h71, 3'b011, '0, '0, '0);
    step();
    drive_idle();
    #2 rst = 1'b1;
    #1;
    check("arst_count", BUSW'(count), BUSW'(0));
    check("arst_bus", iss_bus, BUSW'(0));
    check("arst_valid", BUSW'(inst_valid), BUSW'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_idle();
      fu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) drive_rand_disp();
      flush = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NWB; p++) begin
        if ($urandom_range(0, 2) == 0) drive_wb(p, PRNW'($urandom_range(0, 15)), {$urandom, $urandom});
      end
      step();
    end

    drive_idle();
    check("exp_q_drained", BUSW'(exp_q.size()), BUSW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fu_issue_queue.md
Name: fu_issue_queue

Overview:
- Per-functional-unit reservation station; drives the issue side of the functional-unit handshake (inst_id, inst, op, out_prn, pc, inst_valid).
- Accepts renamed instructions from dispatch, holds them until every source operand is captured, then issues the oldest ready entry to its FU.
- Wakes operands by snooping the writeback bus, which carries FU out[] results (prn, data, valid).

Parameters:
- DEPTH, 8: entries; must be ≥ 2.
- INST_ID_BITS, 8: instruction ID width.
- PRN_BITS, 6: physical register number width.
- MAX_OPERANDS, 3: source operands and destination PRNs per instruction.
- WB_PORTS, 3: writeback broadcast ports snooped.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all entries and any pending issue
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept this cycle
- disp_inst_id  in  INST_ID_BITS  instruction ID
- disp_inst  in  32  instruction word
- disp_pc  in  64  program counter
- disp_src_prn  in  MAX_OPERANDS x PRN_BITS  source tags
- disp_src_rdy  in  MAX_OPERANDS  source already available
- disp_src_val  in  MAX_OPERANDS x 64  source value when rdy
- disp_dst_prn  in  MAX_OPERANDS x PRN_BITS  destination PRNs, passed through
- wb_valid  in  WB_PORTS  broadcast valid
- wb_prn  in  WB_PORTS x PRN_BITS  broadcast tag
- wb_data  in  WB_PORTS x 64  broadcast value
- fu_ready  in  1  FU accepts an issue at the next edge
- inst_valid  out  1  issue valid
- inst_id  out  INST_ID_BITS  issued ID
- inst  out  32  issued instruction
- op  out  MAX_OPERANDS x 64  issued operands
- out_prn  out  MAX_OPERANDS x PRN_BITS  issued destination PRNs
- pc  out  64  issued PC
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: all entries invalid; count=0; inst_valid=0; inst_id, inst, op, out_prn and pc all 0. disp_ready=1 once rst deasserts.
- Storage: collapsing queue; index 0 is oldest. Each entry holds valid, id, inst, pc, dst PRNs, and per-source {prn, rdy, val}.
- disp_ready = (count < DEPTH) && !flush. An entry freed in the same cycle does not raise disp_ready.
- Accept (disp_valid && disp_ready): the entry is written at the first free index after collapse.
  - A source with disp_src_rdy=1 stores disp_src_val.
  - Otherwise, a same-cycle wb match on its tag sets rdy and captures that wb_data.
- Wakeup: each cycle, every valid entry source with rdy=0 compares against all wb ports. On match with wb_valid, it sets rdy=1 and latches data at the edge. If several ports match, the lowest port index wins.
- Select: the lowest-index entry with all MAX_OPERANDS rdy bits set, evaluated on registered state. A wakeup becomes issuable the cycle after capture; there is no wb-to-issue bypass.
- Issue:
  - If a selected entry exists and fu_ready=1, its fields load into the issue output registers at the edge. inst_valid=1 for exactly that following cycle.
  - Entries above it shift down one index in the same edge; count decrements.
  - Otherwise inst_valid=0 next cycle and the other outputs hold their last values.
- Simultaneous accept and issue: count is unchanged, and the new entry lands at index count-1 after the shift.
- Latency: dispatch with all sources ready at edge N → inst_valid high in the cycle after edge N+1 (2 cycles minimum).
- Ordering: an older ready entry always issues before a younger ready one.
- flush: at the next edge all entries are invalidated, count=0 and inst_valid=0. flush overrides same-cycle accept and issue.
- rst mid-operation: immediately clears all state to reset values, regardless of clk.
- count never exceeds DEPTH; dispatch when full is ignored (disp_ready=0).

Test Plan:
- Reset, then dispatch id=5 with srcs rdy, values {1,2,3}, dst {10,11,12}, fu_ready=1 → inst_valid pulses 2 cycles later with inst_id=5, op={1,2,3}, out_prn={10,11,12}; count returns to 0.
- Dispatch id=7 with src0 prn=20 not ready; wb_valid[1]=1, wb_prn[1]=20, wb_data=0xABCD three cycles later → issue on the cycle after capture with op[0]=0xABCD.
- Dispatch ids 1, 2, 3 with only id=3 ready, then wake id=1 → issue order is 3, then 1; id=2 remains; count=1.
- Fill 8 entries with blocked sources → disp_ready=0 and a 9th dispatch is dropped. Wake entry 0 → it issues; disp_ready=1 only after count drops to 7.
- Hold fu_ready=0 with 2 ready entries → no inst_valid. Raise fu_ready → the oldest issues first, on consecutive cycles.
- Flush with count=4 and a same-cycle dispatch → count=0, inst_valid=0 next cycle. Assert rst mid-stream → outputs go to 0 asynchronously.
